// File: rtl/pll_seq_pkg.sv
// Shared types and loop-filter presets for the PLL lock sequencer.
package pll_seq_pkg;

    typedef enum logic [2:0] {
        StRst,
        StWait,
        StStable,
        StEnable,
        StRun
    } state_t;

    typedef struct packed {
        logic [5:0] icp;
        logic [2:0] res;
        logic [1:0] cap;
    } preset_t;

    localparam int unsigned NUM_PRESETS = 4;

    // Loop-filter settings tried in order until one locks.
    localparam preset_t PRESET [0:NUM_PRESETS-1] = '{
        '{icp: 6'd16, res: 3'd2, cap: 2'd0},
        '{icp: 6'd24, res: 3'd3, cap: 2'd0},
        '{icp: 6'd8,  res: 3'd1, cap: 2'd1},
        '{icp: 6'd32, res: 3'd4, cap: 2'd0}
    };

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchronizer for single-bit or multi-bit level signals.
module sync_2ff #(
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    // Two back-to-back flops; first stage may go metastable.
    always_ff @(posedge clk) begin
        if (reset) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/pll_lock_sequencer.sv
// Bring-up and supervision controller for the dynamic-loop-filter PLL.
//
// Sequence: hold pll_reset for RESET_CYCLES, wait for a debounced lock, then
// enable clkout0..2 ENCLK_GAP cycles apart and raise ready. A lock timeout
// steps to the next loop-filter preset; lock loss in ENABLE/RUN re-acquires.
//
// Latency (clkin edges counted from the first edge that samples reset low):
// with pll_lock rising exactly as pll_reset falls, ready rises on edge
// RESET_CYCLES + 2 + LOCK_STABLE + 2*ENCLK_GAP + 2. With pll_lock already high
// and synchronized, it is RESET_CYCLES + LOCK_STABLE + 2*ENCLK_GAP + 2.
module pll_lock_sequencer
    import pll_seq_pkg::*;
#(
    parameter int unsigned RESET_CYCLES = 100,
    parameter int unsigned LOCK_TIMEOUT = 50000,
    parameter int unsigned LOCK_STABLE  = 1024,
    parameter int unsigned ENCLK_GAP    = 16
) (
    input  logic       clkin,
    input  logic       reset,
    input  logic       pll_lock,
    input  logic       restart,
    output logic       pll_reset,
    output logic [5:0] icpsel,
    output logic [2:0] lpfres,
    output logic [1:0] lpfcap,
    output logic [2:0] enclk,
    output logic       ready,
    output logic       fail,
    output logic [1:0] preset_idx,
    output logic [7:0] relock_count
);

    localparam int unsigned CNT_MAX = max_u(max_u(LOCK_TIMEOUT, RESET_CYCLES),
                                            max_u(LOCK_STABLE, 2 * ENCLK_GAP));
    localparam int unsigned CW = $clog2(CNT_MAX + 1);

    localparam logic [CW-1:0] RST_LAST    = CW'(RESET_CYCLES - 1);
    localparam logic [CW-1:0] TO_LAST     = CW'(LOCK_TIMEOUT - 1);
    localparam logic [CW-1:0] STAB_LAST   = CW'(LOCK_STABLE - 1);
    localparam logic [CW-1:0] GAP1_LAST   = CW'(ENCLK_GAP - 1);
    localparam logic [CW-1:0] GAP2_LAST   = CW'(2 * ENCLK_GAP - 1);
    localparam logic [CW-1:0] ENABLE_DONE = CW'(2 * ENCLK_GAP);

    logic lock_s;

    sync_2ff #(
        .WIDTH(1)
    ) u_lock_sync (
        .clk  (clkin),
        .reset(reset),
        .d    (pll_lock),
        .q    (lock_s)
    );

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;     // reset hold in RST, enclk spacing in ENABLE
    logic [CW-1:0] to_q, to_d;       // lock timeout across WAIT and STABLE
    logic [CW-1:0] stab_q, stab_d;
    logic [1:0]    preset_q, preset_d;
    logic          fail_q, fail_d;
    logic [7:0]    relock_q, relock_d;
    logic          pll_reset_q, pll_reset_d;
    logic [2:0]    enclk_q, enclk_d;
    logic          ready_q, ready_d;
    preset_t       lpf_q;

    // Next-state and registered-output decode.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        to_d        = to_q;
        stab_d      = stab_q;
        preset_d    = preset_q;
        fail_d      = fail_q;
        relock_d    = relock_q;
        pll_reset_d = pll_reset_q;
        enclk_d     = enclk_q;
        ready_d     = ready_q;

        if (restart) begin
            state_d     = StRst;
            cnt_d       = '0;
            preset_d    = 2'd0;
            fail_d      = 1'b0;
            pll_reset_d = 1'b1;
            enclk_d     = 3'b000;
            ready_d     = 1'b0;
        end else begin
            case (state_q)
                StRst: begin
                    pll_reset_d = 1'b1;
                    if (cnt_q == RST_LAST) begin
                        state_d     = StWait;
                        pll_reset_d = 1'b0;
                        cnt_d       = '0;
                        to_d        = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                StWait, StStable: begin
                    if (to_q == TO_LAST) begin
                        // Preset index wraps 3 -> 0 by width.
                        state_d     = StRst;
                        cnt_d       = '0;
                        preset_d    = preset_q + 2'd1;
                        pll_reset_d = 1'b1;
                        if (preset_q == 2'd3) begin
                            fail_d = 1'b1;
                        end
                    end else begin
                        to_d = to_q + 1'b1;
                        if (state_q == StWait) begin
                            if (lock_s) begin
                                state_d = StStable;
                                stab_d  = '0;
                            end
                        end else if (!lock_s) begin
                            // Timeout keeps running so a flapping lock still expires.
                            state_d = StWait;
                        end else if (stab_q == STAB_LAST) begin
                            state_d = StEnable;
                            cnt_d   = '0;
                            enclk_d = 3'b001;
                        end else begin
                            stab_d = stab_q + 1'b1;
                        end
                    end
                end
                StEnable, StRun: begin
                    if (!lock_s) begin
                        state_d     = StRst;
                        cnt_d       = '0;
                        enclk_d     = 3'b000;
                        ready_d     = 1'b0;
                        pll_reset_d = 1'b1;
                        if (relock_q != 8'hff) begin
                            relock_d = relock_q + 8'd1;
                        end
                    end else if (state_q == StEnable) begin
                        cnt_d = cnt_q + 1'b1;
                        if (cnt_q == GAP1_LAST) begin
                            enclk_d[1] = 1'b1;
                        end
                        if (cnt_q == GAP2_LAST) begin
                            enclk_d[2] = 1'b1;
                        end
                        if (cnt_q == ENABLE_DONE) begin
                            state_d = StRun;
                            ready_d = 1'b1;
                        end
                    end
                end
                default: begin
                    state_d     = StRst;
                    cnt_d       = '0;
                    pll_reset_d = 1'b1;
                    enclk_d     = 3'b000;
                    ready_d     = 1'b0;
                end
            endcase
        end
    end

    // State and output registers; preset outputs track the next index.
    always_ff @(posedge clkin) begin
        if (reset) begin
            state_q     <= StRst;
            cnt_q       <= '0;
            to_q        <= '0;
            stab_q      <= '0;
            preset_q    <= 2'd0;
            fail_q      <= 1'b0;
            relock_q    <= 8'd0;
            pll_reset_q <= 1'b1;
            enclk_q     <= 3'b000;
            ready_q     <= 1'b0;
            lpf_q       <= PRESET[0];
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            to_q        <= to_d;
            stab_q      <= stab_d;
            preset_q    <= preset_d;
            fail_q      <= fail_d;
            relock_q    <= relock_d;
            pll_reset_q <= pll_reset_d;
            enclk_q     <= enclk_d;
            ready_q     <= ready_d;
            lpf_q       <= PRESET[preset_d];
        end
    end

    assign pll_reset    = pll_reset_q;
    assign icpsel       = lpf_q.icp;
    assign lpfres       = lpf_q.res;
    assign lpfcap       = lpf_q.cap;
    assign enclk        = enclk_q;
    assign ready        = ready_q;
    assign fail         = fail_q;
    assign preset_idx   = preset_q;
    assign relock_count = relock_q;

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Directed self-checking bench for pll_lock_sequencer.
module tb_pll_lock_sequencer;

    logic       clkin = 1'b0;
    logic       reset;
    logic       pll_lock;
    logic       restart;
    logic       pll_reset;
    logic [5:0] icpsel;
    logic [2:0] lpfres;
    logic [1:0] lpfcap;
    logic [2:0] enclk;
    logic       ready;
    logic       fail;
    logic [1:0] preset_idx;
    logic [7:0] relock_count;

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;

    pll_lock_sequencer #(
        .RESET_CYCLES(4),
        .LOCK_TIMEOUT(64),
        .LOCK_STABLE (8),
        .ENCLK_GAP   (2)
    ) dut (
        .clkin       (clkin),
        .reset       (reset),
        .pll_lock    (pll_lock),
        .restart     (restart),
        .pll_reset   (pll_reset),
        .icpsel      (icpsel),
        .lpfres      (lpfres),
        .lpfcap      (lpfcap),
        .enclk       (enclk),
        .ready       (ready),
        .fail        (fail),
        .preset_idx  (preset_idx),
        .relock_count(relock_count)
    );

    always #5 clkin = ~clkin;

    task automatic step(input int n);
        repeat (n) @(posedge clkin);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    initial begin
        reset    = 1'b1;
        pll_lock = 1'b0;
        restart  = 1'b0;
        step(2);

        // Reset values
        check("rst_pll_reset", pll_reset, 1);
        check("rst_preset", preset_idx, 0);
        check("rst_icpsel", icpsel, 16);
        check("rst_lpfres", lpfres, 2);
        check("rst_lpfcap", lpfcap, 0);
        check("rst_enclk", enclk, 0);
        check("rst_ready", ready, 0);
        check("rst_fail", fail, 0);
        check("rst_relock", relock_count, 0);

        // Nominal bring-up: edge numbers below are relative to reset release
        reset = 1'b0;
        step(3);
        check("nom_pll_reset_held", pll_reset, 1);
        step(1);
        check("nom_pll_reset_fell", pll_reset, 0);
        step(10);
        pll_lock = 1'b1;
        step(10);
        check("nom_enclk_pre", enclk, 3'b000);
        step(1);
        check("nom_enclk_001", enclk, 3'b001);
        step(1);
        check("nom_enclk_001_hold", enclk, 3'b001);
        step(1);
        check("nom_enclk_011", enclk, 3'b011);
        step(2);
        check("nom_enclk_111", enclk, 3'b111);
        check("nom_ready_pre", ready, 0);
        step(1);
        check("nom_ready", ready, 1);
        check("nom_preset", preset_idx, 0);
        check("nom_icpsel", icpsel, 16);
        check("nom_pll_reset_low", pll_reset, 0);

        // Lock loss in RUN: 1-cycle drop is acted on at the third edge
        pll_lock = 1'b0;
        step(1);
        pll_lock = 1'b1;
        step(1);
        check("loss_ready_still", ready, 1);
        step(1);
        check("loss_enclk", enclk, 3'b000);
        check("loss_ready", ready, 0);
        check("loss_pll_reset", pll_reset, 1);
        check("loss_relock", relock_count, 1);
        check("loss_preset", preset_idx, 0);
        step(17);
        check("reacq_ready_pre", ready, 0);
        step(1);
        check("reacq_ready", ready, 1);
        check("reacq_enclk", enclk, 3'b111);

        // 299 more losses: relock_count saturates at 255
        for (int i = 0; i < 299; i++) begin
            pll_lock = 1'b0;
            step(1);
            pll_lock = 1'b1;
            step(20);
            if (i == 252) check("relock_254", relock_count, 254);
        end
        check("relock_sat", relock_count, 255);
        check("relock_sat_ready", ready, 1);

        // Mid-operation reset during ENABLE with enclk=011
        pll_lock = 1'b0;
        step(1);
        pll_lock = 1'b1;
        step(2);
        check("relock_sat_hold", relock_count, 255);
        step(15);
        check("mid_enclk_011", enclk, 3'b011);
        reset = 1'b1;
        step(1);
        check("mid_pll_reset", pll_reset, 1);
        check("mid_enclk", enclk, 0);
        check("mid_ready", ready, 0);
        check("mid_relock", relock_count, 0);
        check("mid_preset", preset_idx, 0);
        reset = 1'b0;

        // Flapping lock (5 high, 1 low): never enables, times out at edge 68
        for (int k = 1; k <= 68; k++) begin
            step(1);
            if (k == 4) check("flap_pll_reset_fell", pll_reset, 0);
            if (k == 67) begin
                check("flap_pre_pll_reset", pll_reset, 0);
                check("flap_pre_preset", preset_idx, 0);
                check("flap_pre_enclk", enclk, 0);
            end
            if (k == 68) begin
                check("flap_to_pll_reset", pll_reset, 1);
                check("flap_to_preset", preset_idx, 1);
                check("flap_to_icpsel", icpsel, 24);
                check("flap_to_lpfres", lpfres, 3);
                check("flap_to_enclk", enclk, 0);
            end
            pll_lock = ((k % 6) != 0);
        end

        // Timeout stepping with lock held low: 68-edge period per preset
        pll_lock = 1'b0;
        step(3);
        check("step_rst_held", pll_reset, 1);
        step(1);
        check("step_rst_fell", pll_reset, 0);
        step(63);
        check("step1_pre", preset_idx, 1);
        step(1);
        check("step2_preset", preset_idx, 2);
        check("step2_icpsel", icpsel, 8);
        check("step2_lpfres", lpfres, 1);
        check("step2_lpfcap", lpfcap, 1);
        check("step2_fail", fail, 0);
        step(68);
        check("step3_preset", preset_idx, 3);
        check("step3_icpsel", icpsel, 32);
        check("step3_lpfres", lpfres, 4);
        step(67);
        check("step3_fail_pre", fail, 0);
        step(1);
        check("step0_preset", preset_idx, 0);
        check("step0_icpsel", icpsel, 16);
        check("step0_fail", fail, 1);
        step(68);
        check("step1b_preset", preset_idx, 1);
        check("step1b_fail", fail, 1);
        step(68);
        check("step2b_preset", preset_idx, 2);
        check("step2b_fail", fail, 1);

        // Restart on the same cycle as a timeout wins over the timeout
        step(67);
        restart = 1'b1;
        step(1);
        restart = 1'b0;
        check("rs_preset", preset_idx, 0);
        check("rs_fail", fail, 0);
        check("rs_icpsel", icpsel, 16);
        check("rs_pll_reset", pll_reset, 1);
        step(3);
        check("rs_pll_reset_held", pll_reset, 1);
        step(1);
        check("rs_pll_reset_fell", pll_reset, 0);
        check("rs_relock_kept", relock_count, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
